// File: rtl/countdown_if.sv
// countdown_if: button input and display-digit outputs of the countdown stage
interface countdown_if;
  logic        btn_raw;
  logic [31:0] digits;
  logic [7:0]  blank;
  logic        running;
  logic        done;
  modport master (output btn_raw, input digits, blank, running, done);
  modport slave  (input btn_raw, output digits, blank, running, done);
endinterface

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: debounced start/pause/resume multi-pass BCD countdown feeding the display controller
module countdown_ctrl #(
  parameter int          DEB_CYCLES  = 4,
  parameter int          TICK_CYCLES = 32,
  parameter logic [7:0]  START_VAL   = 8'h10,
  parameter int          RELOADS     = 1,
  parameter logic [23:0] ID_BCD      = 24'h202108
) (
  input logic        clk,
  input logic        rst_n,
  countdown_if.slave bus
);
  localparam int DW = $clog2(DEB_CYCLES);
  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] TICK_MAX = PW'(TICK_CYCLES - 1);
  localparam logic [2:0]    PASS_MAX = 3'(RELOADS);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] sync;
  logic [DW-1:0] deb_cnt;
  logic btn_db, btn_db_d, press, tick;
  logic [PW-1:0] pre, pre_nx;
  logic [7:0] count, count_nx, count_dec;
  logic [2:0] pass, pass_nx;
  // btn_db flips on the DEB_CYCLES-th consecutive cycle of disagreement
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync     <= '0;
      deb_cnt  <= '0;
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
    end else begin
      sync     <= {sync[0], bus.btn_raw};
      btn_db_d <= btn_db;
      if (sync[1] == btn_db) deb_cnt <= '0;
      else if (deb_cnt == DEB_MAX) begin
        deb_cnt <= '0;
        btn_db  <= ~btn_db;
      end else deb_cnt <= deb_cnt + 1'b1;
    end
  assign press     = btn_db & ~btn_db_d;
  assign tick      = pre == TICK_MAX;
  assign count_dec = count[3:0] == 4'd0 ? {count[7:4] - 4'd1, 4'd9} : {count[7:4], count[3:0] - 4'd1};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      count <= START_VAL;
      pass  <= '0;
      pre   <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      pass  <= pass_nx;
      pre   <= pre_nx;
    end
  // a press in RUN wins over a coincident tick, leaving the prescaler parked
  always_comb begin
    state_nx = state;
    count_nx = count;
    pass_nx  = pass;
    pre_nx   = pre;
    case (state)
      IDLE, DONE: if (press) begin
        state_nx = RUN;
        count_nx = START_VAL;
        pass_nx  = '0;
        pre_nx   = '0;
      end
      RUN: if (press) state_nx = PAUSE;
      else begin
        pre_nx = tick ? '0 : pre + 1'b1;
        if (tick) begin
          if (count != 8'h00) count_nx = count_dec;
          else if (pass < PASS_MAX) begin
            pass_nx  = pass + 3'd1;
            count_nx = START_VAL;
          end else state_nx = DONE;
        end
      end
      PAUSE: if (press) state_nx = RUN;
    endcase
  end
  assign bus.digits  = {ID_BCD, count};
  assign bus.blank   = state == IDLE ? 8'hFF : 8'h00;
  assign bus.running = state == RUN;
  assign bus.done    = state == DONE;
endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: scoreboard bench; expected display events queued with stimulus, popped on each output change
module tb_countdown_ctrl;
  typedef struct {
    logic [7:0] cnt;
    logic       run;
    logic       dn;
    logic [7:0] bl;
    int         gap;
  } ev_t;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_cyc = 0;
  int run_cycles = 0;
  int run_base;
  logic mon_en = 1'b0;
  logic [17:0] prev_snap = {8'h10, 1'b0, 1'b0, 8'hFF};
  logic [17:0] cur;
  ev_t e;
  ev_t sb[$];
  countdown_if bus();
  countdown_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] to_bcd(input int d);
    return {4'(d / 10), 4'(d % 10)};
  endfunction
  task automatic push(input logic [7:0] c, input logic r, input logic d, input logic [7:0] b, input int g);
    ev_t x;
    x.cnt = c; x.run = r; x.dn = d; x.bl = b; x.gap = g;
    sb.push_back(x);
  endtask
  task automatic push_seq(input int hi, input int lo);
    for (int d = hi; d >= lo; d--) push(to_bcd(d), 1'b1, 1'b0, 8'h00, 32);
  endtask
  task automatic push_rest_pass();
    push(8'h10, 1'b1, 1'b0, 8'h00, 32);
    push_seq(9, 0);
    push(8'h00, 1'b0, 1'b1, 8'h00, 32);
  endtask
  task automatic press(input int hold);
    @(posedge clk);
    #1 bus.btn_raw = 1'b1;
    repeat (hold) @(posedge clk);
    #1 bus.btn_raw = 1'b0;
  endtask
  task automatic wait_cnt(input logic [7:0] v, input int budget);
    int n = 0;
    while (bus.digits[7:0] !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_cnt", 32'(bus.digits[7:0]), 32'(v));
  endtask
  task automatic wait_done(input int budget);
    int n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_done", 32'(bus.done), 32'd1);
  endtask
  always @(negedge clk) begin
    if (bus.running === 1'b1) run_cycles++;
    if (mon_en) begin
      cur = {bus.digits[7:0], bus.running, bus.done, bus.blank};
      if (cur !== prev_snap) begin
        if (sb.size() == 0) check("unexpected_ev", 32'(cur), 32'(prev_snap));
        else begin
          e = sb.pop_front();
          check("ev_cnt", 32'(bus.digits[7:0]), 32'(e.cnt));
          check("ev_running", 32'(bus.running), 32'(e.run));
          check("ev_done", 32'(bus.done), 32'(e.dn));
          check("ev_blank", 32'(bus.blank), 32'(e.bl));
          check("ev_id", 32'(bus.digits[31:8]), 32'h202108);
          if (e.gap >= 0) check("ev_gap", 32'(cyc - last_cyc), 32'(e.gap));
        end
        last_cyc = cyc;
        prev_snap = cur;
      end
    end
  end
  initial begin
    rst_n = 1'b0;
    bus.btn_raw = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1 bus.btn_raw = ~bus.btn_raw;
    end
    @(negedge clk);
    mon_en = 1'b1;
    check("rst_digits", bus.digits, 32'h20210810);
    check("rst_blank", 32'(bus.blank), 32'hFF);
    check("rst_running", 32'(bus.running), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    bus.btn_raw = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_digits", bus.digits, 32'h20210810);
    check("post_rst_blank", 32'(bus.blank), 32'hFF);
    check("post_rst_running", 32'(bus.running), 32'd0);
    // three-cycle highs are one short of the debounce window
    repeat (5) begin
      @(posedge clk);
      #1 bus.btn_raw = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.btn_raw = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("glitch_blank", 32'(bus.blank), 32'hFF);
      check("glitch_running", 32'(bus.running), 32'd0);
    end
    repeat (5) @(negedge clk);
    push(8'h10, 1'b1, 1'b0, 8'h00, -1);
    push_seq(9, 0);
    push_rest_pass();
    run_base = run_cycles;
    press(750);
    repeat (20) @(negedge clk);
    check("held_done", 32'(bus.done), 32'd1);
    check("held_running", 32'(bus.running), 32'd0);
    check("clean_run_cycles", 32'(run_cycles - run_base), 32'd704);
    push(8'h10, 1'b1, 1'b0, 8'h00, -1);
    push_seq(9, 7);
    run_base = run_cycles;
    press(10);
    wait_cnt(8'h07, 2000);
    push(8'h07, 1'b0, 1'b0, 8'h00, -1);
    press(10);
    repeat (300) @(negedge clk);
    check("pause_cnt", 32'(bus.digits[7:0]), 32'h07);
    check("pause_running", 32'(bus.running), 32'd0);
    push(8'h07, 1'b1, 1'b0, 8'h00, -1);
    push(8'h06, 1'b1, 1'b0, 8'h00, -1);
    push_seq(5, 0);
    push_rest_pass();
    press(10);
    wait_done(2000);
    // the RUN cycle that takes the pause press does not advance the prescaler
    check("pause_run_cycles", 32'(run_cycles - run_base), 32'd705);
    push(8'h10, 1'b1, 1'b0, 8'h00, -1);
    push_seq(9, 5);
    press(10);
    wait_cnt(8'h05, 2000);
    push(8'h05, 1'b0, 1'b0, 8'h00, 32);
    repeat (24) @(posedge clk);
    press(10);
    repeat (50) @(negedge clk);
    check("coinc_cnt", 32'(bus.digits[7:0]), 32'h05);
    push(8'h05, 1'b1, 1'b0, 8'h00, -1);
    push(8'h04, 1'b1, 1'b0, 8'h00, 1);
    push_seq(3, 0);
    push(8'h10, 1'b1, 1'b0, 8'h00, 32);
    push_seq(9, 3);
    press(10);
    wait_cnt(8'h10, 2000);
    wait_cnt(8'h03, 2000);
    push(8'h10, 1'b0, 1'b0, 8'hFF, -1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_digits", bus.digits, 32'h20210810);
    check("arst_blank", 32'(bus.blank), 32'hFF);
    check("arst_running", 32'(bus.running), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    push(8'h10, 1'b1, 1'b0, 8'h00, -1);
    push_seq(9, 0);
    push_rest_pass();
    press(10);
    wait_done(2000);
    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
